// File: rtl/sort_stat_pkg.sv
// ============================================================================
// Module  : sort_stat_pkg
// Purpose : Shared types and constants for the sort_stat result engine.
//           Optional macro SORT_STAT_ORDER_CHECK_EN adds the order-violation beat.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package sort_stat_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CALC    = 2'd2,
        OUT     = 2'd3
    } state_t;

    localparam int RES_IDX_W = 3;

    localparam logic [RES_IDX_W-1:0] RES_SUM  = 3'd0;
    localparam logic [RES_IDX_W-1:0] RES_MAX  = 3'd1;
    localparam logic [RES_IDX_W-1:0] RES_MIN  = 3'd2;
    localparam logic [RES_IDX_W-1:0] RES_MED  = 3'd3;
    localparam logic [RES_IDX_W-1:0] RES_DIST = 3'd4;
    localparam logic [RES_IDX_W-1:0] RES_VIOL = 3'd5;

`ifdef SORT_STAT_ORDER_CHECK_EN
    localparam logic [RES_IDX_W-1:0] RES_CNT  = 3'd6;
`else
    localparam logic [RES_IDX_W-1:0] RES_CNT  = 3'd5;
`endif

    // Sum of N values of W bits needs clog2(N) extra bits of headroom.
    function automatic int sum_w_f(input int n, input int w);
        return w + $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sort_stat_if.sv
// ============================================================================
// Module  : sort_stat_if
// Purpose : Frame input / result output bundle between sorter and sort_stat.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface sort_stat_if
    import sort_stat_pkg::*;
#(
    parameter int W     = 5,
    parameter int SUM_W = sum_w_f(10, W)
);
    logic             in_valid;
    logic [W-1:0]     in;
    logic             out_valid;
    logic [SUM_W-1:0] out;
    logic             frame_err;
    logic             overrun;

    modport master (
        output in_valid, in,
        input  out_valid, out, frame_err, overrun
    );

    modport slave (
        input  in_valid, in,
        output out_valid, out, frame_err, overrun
    );
endinterface

`default_nettype wire

// File: rtl/sort_stat_acc.sv
// ============================================================================
// Module  : sort_stat_acc
// Purpose : Per-beat statistics datapath (sum/max/min/distinct/median).
//           SORT_STAT_ORDER_CHECK_EN adds the ascending-step violation counter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sort_stat_acc #(
    parameter int N      = 10,
    parameter int W      = 5,
    parameter int SUM_W  = 9,
    parameter int CNT_W  = 4,
    parameter int DIST_W = 4,
    parameter int VIOL_W = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_first,
    input  wire logic              i_beat,
    input  wire logic              i_calc,
    input  wire logic [CNT_W-1:0]  i_idx,
    input  wire logic [W-1:0]      i_data,
    output logic      [SUM_W-1:0]  o_sum,
    output logic      [W-1:0]      o_max,
    output logic      [W-1:0]      o_min,
    output logic      [DIST_W-1:0] o_dist,
`ifdef SORT_STAT_ORDER_CHECK_EN
    output logic      [VIOL_W-1:0] o_viol,
`endif
    output logic      [W-1:0]      o_med
);

    localparam logic [CNT_W-1:0] c_MED_A = CNT_W'(N/2 - 1);
    localparam logic [CNT_W-1:0] c_MED_B = CNT_W'(N/2);

    logic [SUM_W-1:0]  r_sum;
    logic [W-1:0]      r_max;
    logic [W-1:0]      r_min;
    logic [W-1:0]      r_prev;
    logic [DIST_W-1:0] r_dist;
    logic [W-1:0]      r_med_a;
    logic [W-1:0]      r_med_b;
    logic [W-1:0]      r_med;
    logic [W:0]        w_med_sum;
    logic              w_take;

    assign w_take    = i_first | i_beat;
    assign w_med_sum = {1'b0, r_med_a} + {1'b0, r_med_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= '0;
            r_max   <= '0;
            r_min   <= '0;
            r_prev  <= '0;
            r_dist  <= '0;
            r_med_a <= '0;
            r_med_b <= '0;
            r_med   <= '0;
        end else begin
            if (i_first) begin
                r_sum  <= SUM_W'(i_data);
                r_max  <= i_data;
                r_min  <= i_data;
                r_prev <= i_data;
                r_dist <= DIST_W'(1);
            end else if (i_beat) begin
                r_sum  <= r_sum + SUM_W'(i_data);
                if (i_data > r_max) r_max <= i_data;
                if (i_data < r_min) r_min <= i_data;
                if (i_data != r_prev) r_dist <= r_dist + DIST_W'(1);
                r_prev <= i_data;
            end
            // Index 0 can be a median tap when N=2, so both accept paths count.
            if (w_take && (i_idx == c_MED_A)) r_med_a <= i_data;
            if (w_take && (i_idx == c_MED_B)) r_med_b <= i_data;
            if (i_calc) r_med <= w_med_sum[W:1];
        end
    end

`ifdef SORT_STAT_ORDER_CHECK_EN
    logic [VIOL_W-1:0] r_viol;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_viol <= '0;
        end else if (i_first) begin
            r_viol <= '0;
        end else if (i_beat && (i_data > r_prev)) begin
            r_viol <= r_viol + VIOL_W'(1);
        end
    end

    assign o_viol = r_viol;
`endif

    assign o_sum  = r_sum;
    assign o_max  = r_max;
    assign o_min  = r_min;
    assign o_dist = r_dist;
    assign o_med  = r_med;

endmodule

`default_nettype wire

// File: rtl/sort_stat.sv
// ============================================================================
// Module  : sort_stat
// Purpose : Captures one sorted frame and emits sum/max/min/median/distinct.
//           SORT_STAT_ORDER_CHECK_EN appends an order-violation count beat.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sort_stat
    import sort_stat_pkg::*;
#(
    parameter int N     = 10,
    parameter int W     = 5,
    parameter int SUM_W = sum_w_f(N, W)
) (
    input  wire logic clk,
    input  wire logic rst,
    sort_stat_if.slave bus
);

    localparam int CNT_W  = $clog2(N + 1);
    localparam int DIST_W = $clog2(N + 1);
    localparam int VIOL_W = $clog2(N);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N - 1);

    state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [RES_IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [RES_IDX_W-1:0]   w_sel;
    logic [SUM_W-1:0]       r_out, w_out_nxt, w_mux;
    logic                   r_out_valid, w_out_valid_nxt;
    logic                   r_frame_err, w_frame_err_nxt;
    logic                   r_overrun;
    logic                   r_blk;
    logic                   w_busy;
    logic                   w_first, w_beat, w_calc;

    logic [SUM_W-1:0]       w_sum;
    logic [W-1:0]           w_max, w_min, w_med;
    logic [DIST_W-1:0]      w_dist;
`ifdef SORT_STAT_ORDER_CHECK_EN
    logic [VIOL_W-1:0]      w_viol;
`endif

    sort_stat_acc #(
        .N      (N),
        .W      (W),
        .SUM_W  (SUM_W),
        .CNT_W  (CNT_W),
        .DIST_W (DIST_W),
        .VIOL_W (VIOL_W)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .i_first (w_first),
        .i_beat  (w_beat),
        .i_calc  (w_calc),
        .i_idx   (r_cnt),
        .i_data  (bus.in),
        .o_sum   (w_sum),
        .o_max   (w_max),
        .o_min   (w_min),
        .o_dist  (w_dist),
`ifdef SORT_STAT_ORDER_CHECK_EN
        .o_viol  (w_viol),
`endif
        .o_med   (w_med)
    );

    assign w_busy = (r_state == CALC) || (r_state == OUT);

    // CALC already presents beat 0; OUT presents the beat at r_idx.
    assign w_sel = (r_state == CALC) ? RES_SUM : r_idx;

    always_comb begin
        w_mux = '0;
        case (w_sel)
            RES_SUM:  w_mux = w_sum;
            RES_MAX:  w_mux = SUM_W'(w_max);
            RES_MIN:  w_mux = SUM_W'(w_min);
            RES_MED:  w_mux = SUM_W'(w_med);
            RES_DIST: w_mux = SUM_W'(w_dist);
`ifdef SORT_STAT_ORDER_CHECK_EN
            RES_VIOL: w_mux = SUM_W'(w_viol);
`endif
            default:  w_mux = '0;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_out_nxt       = '0;
        w_out_valid_nxt = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_first         = 1'b0;
        w_beat          = 1'b0;
        w_calc          = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid && !r_blk) begin
                    w_first     = 1'b1;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.in_valid) begin
                    w_beat = 1'b1;
                    if (r_cnt == c_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = CALC;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_frame_err_nxt = 1'b1;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = IDLE;
                end
            end
            CALC: begin
                w_calc          = 1'b1;
                w_out_nxt       = w_mux;
                w_out_valid_nxt = 1'b1;
                w_idx_nxt       = RES_IDX_W'(1);
                w_state_nxt     = OUT;
            end
            OUT: begin
                if (r_idx == RES_CNT) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_out_nxt       = w_mux;
                    w_out_valid_nxt = 1'b1;
                    w_idx_nxt       = r_idx + RES_IDX_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_blk       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= bus.in_valid && w_busy;
            // A stream that began while busy stays rejected until in_valid drops.
            r_blk       <= bus.in_valid && (w_busy || r_blk);
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;

endmodule

`default_nettype wire
